// File: rtl/clock_meter_pkg.sv
// Shared types and helpers for the clock period meter and its input conditioning.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    TIMEOUT
  } meter_state_t;

  // Cycles after reset before the synchronizer output reflects the real input.
  localparam int SYNC_SETTLE = 2;

  function automatic int meter_width(input int counter_max);
    return $clog2(4 * counter_max + 1);
  endfunction

  // Signed difference one bit wider than the operands, so no wrap-around.
  function automatic logic in_tol(input logic [31:0] value,
                                  input logic [31:0] nominal,
                                  input logic [31:0] tol);
    logic signed [32:0] diff;
    diff = $signed({1'b0, value}) - $signed({1'b0, nominal});
    if (diff < 0) diff = -diff;
    return diff <= $signed({1'b0, tol});
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop; reports level and single-cycle rise/fall.
module sync_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // NOTE: sequential state uses non-blocking assignments and clears on the
  // asynchronous active-low reset so every flop starts from a known value.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in cycles
// and reports lock against the nominal divider setting, or timeout when it stalls.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int COUNTER_MAX = 20000,
  parameter int TOLERANCE   = 2,
  parameter int LOCK_COUNT  = 4,
  localparam int W          = meter_width(COUNTER_MAX)
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         sig_in,
  output logic [W-1:0] period_out,
  output logic [W-1:0] high_out,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0]  LIMIT      = W'(4 * COUNTER_MAX);
  localparam logic [31:0]   NOM_PERIOD = 32'(2 * COUNTER_MAX);
  localparam logic [31:0]   NOM_HIGH   = 32'(COUNTER_MAX);
  localparam logic [31:0]   TOL        = 32'(TOLERANCE);
  localparam logic [MW-1:0] LOCK_MAX   = MW'(LOCK_COUNT);

  logic level;
  logic rise;
  logic fall;

  sync_edge u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .async_in (sig_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  meter_state_t  state;
  logic [W-1:0]  elapsed;
  logic [W-1:0]  high_pend;
  logic [MW-1:0] match;

  logic [W-1:0]  elapsed_inc;
  logic [MW-1:0] match_inc;
  logic          period_ok;

  assign elapsed_inc = (elapsed == LIMIT) ? elapsed : elapsed + 1'b1;
  assign match_inc   = (match == LOCK_MAX) ? match : match + 1'b1;
  assign period_ok   = in_tol(32'(elapsed), NOM_PERIOD, TOL) &&
                       in_tol(32'(high_pend), NOM_HIGH, TOL);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      elapsed    <= '0;
      high_pend  <= '0;
      match      <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: default-low here makes valid a single-cycle pulse without extra logic.
      valid <= 1'b0;
      case (state)
        // The elapsed counter doubles as a settle timer so the reset-zero of the
        // synchronizer is not mistaken for a genuine low level.
        IDLE: begin
          elapsed <= elapsed_inc;
          if (elapsed >= W'(SYNC_SETTLE) && !level) state <= ARMED;
        end
        ARMED: begin
          if (rise) begin
            elapsed <= W'(1);
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out <= elapsed;
            high_out   <= high_pend;
            valid      <= 1'b1;
            elapsed    <= W'(1);
            if (period_ok) begin
              match  <= match_inc;
              locked <= (match_inc == LOCK_MAX);
            end else begin
              match  <= '0;
              locked <= 1'b0;
            end
          end else if (elapsed == LIMIT) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
            locked  <= 1'b0;
            match   <= '0;
          end else begin
            elapsed <= elapsed_inc;
            if (fall) high_pend <= elapsed;
          end
        end
        TIMEOUT: begin
          if (rise) begin
            timeout <= 1'b0;
            elapsed <= W'(1);
            state   <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with COUNTER_MAX=10, TOLERANCE=1, LOCK_COUNT=3.
module tb_clock_period_meter;
  import clock_meter_pkg::*;

  localparam int CM  = 10;
  localparam int TOL = 1;
  localparam int LC  = 3;
  localparam int W   = meter_width(CM);

  logic         clk_in = 1'b0;
  logic         reset  = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         valid;
  logic         locked;
  logic         timeout;

  typedef struct {
    int   per;
    int   hi;
    logic lk;
  } rec_t;

  rec_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  int   to_cyc = 0;
  logic to_seen = 1'b0;
  logic to_locked = 1'b0;

  clock_period_meter #(
    .COUNTER_MAX (CM),
    .TOLERANCE   (TOL),
    .LOCK_COUNT  (LC)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc = cyc + 1;

  // Record every valid pulse and the first timeout assertion, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (valid) begin
      q.push_back('{int'(period_out), int'(high_out), locked});
      last_valid_cyc = cyc;
    end
    if (timeout && !to_seen) begin
      to_seen   = 1'b1;
      to_cyc    = cyc;
      to_locked = locked;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    sig_in = v;
    step(n);
  endtask

  task automatic wave(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    sig_in = 1'b0;
    step(3);
    tests++; if (period_out !== '0) begin fails++; $display("FAIL reset_period: got %0d expected 0", period_out); end
    tests++; if (high_out !== '0) begin fails++; $display("FAIL reset_high: got %0d expected 0", high_out); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
    reset = 1'b1;
    step(5);
  endtask

  task automatic test_nominal;
    logic exp_lk [4];
    exp_lk = '{1'b0, 1'b0, 1'b1, 1'b1};
    q.delete();
    wave(10, 10);
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL nominal_first_rise: got %0d valids expected 0", q.size()); end
    repeat (4) wave(10, 10);
    tests++; if (q.size() !== 4) begin fails++; $display("FAIL nominal_count: got %0d valids expected 4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      tests++;
      if (q[i].per !== 20 || q[i].hi !== 10 || q[i].lk !== exp_lk[i]) begin
        fails++;
        $display("FAIL nominal_%0d: got %0d/%0d lock %0b expected 20/10 lock %0b",
                 i, q[i].per, q[i].hi, q[i].lk, exp_lk[i]);
      end
    end
    q.delete();
  endtask

  task automatic test_tolerance;
    int   exp_per [6];
    int   exp_hi  [6];
    logic exp_lk  [6];
    exp_per = '{20, 21, 22, 20, 20, 20};
    exp_hi  = '{10, 11, 12, 10, 10, 10};
    exp_lk  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    wave(11, 10);
    wave(12, 10);
    repeat (4) wave(10, 10);
    tests++; if (q.size() !== 6) begin fails++; $display("FAIL tol_count: got %0d valids expected 6", q.size()); end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      tests++;
      if (q[i].per !== exp_per[i] || q[i].hi !== exp_hi[i] || q[i].lk !== exp_lk[i]) begin
        fails++;
        $display("FAIL tol_%0d: got %0d/%0d lock %0b expected %0d/%0d lock %0b",
                 i, q[i].per, q[i].hi, q[i].lk, exp_per[i], exp_hi[i], exp_lk[i]);
      end
    end
    q.delete();
  endtask

  task automatic test_stall;
    to_seen = 1'b0;
    drive(1'b0, 60);
    tests++; if (to_seen !== 1'b1) begin fails++; $display("FAIL stall_timeout_seen: got %0b expected 1", to_seen); end
    tests++; if (to_seen && (to_cyc - last_valid_cyc) !== 40) begin
      fails++; $display("FAIL stall_latency: got %0d cycles expected 40", to_cyc - last_valid_cyc);
    end
    tests++; if (to_locked !== 1'b0) begin fails++; $display("FAIL stall_locked: got %0b expected 0", to_locked); end
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL stall_no_valid: got %0d valids expected 0", q.size()); end
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL stall_timeout_held: got %0b expected 1", timeout); end
    q.delete();
  endtask

  task automatic test_recovery;
    drive(1'b1, 10);
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL recover_timeout: got %0b expected 0", timeout); end
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL recover_first_rise: got %0d valids expected 0", q.size()); end
    drive(1'b0, 10);
    wave(10, 10);
    wave(10, 10);
    tests++; if (q.size() !== 2) begin fails++; $display("FAIL recover_count: got %0d valids expected 2", q.size()); end
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      tests++;
      if (q[i].per !== 20 || q[i].hi !== 10 || q[i].lk !== 1'b0) begin
        fails++;
        $display("FAIL recover_%0d: got %0d/%0d lock %0b expected 20/10 lock 0",
                 i, q[i].per, q[i].hi, q[i].lk);
      end
    end
    q.delete();
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 5);
    reset = 1'b0;
    #1;
    q.delete();
    tests++; if (period_out !== '0 || high_out !== '0) begin
      fails++; $display("FAIL mid_reset_data: got %0d/%0d expected 0/0", period_out, high_out);
    end
    tests++; if ({valid, locked, timeout} !== 3'b000) begin
      fails++; $display("FAIL mid_reset_flags: got %03b expected 000", {valid, locked, timeout});
    end
    step(2);
    reset = 1'b1;
    drive(1'b1, 8);
    drive(1'b0, 10);
    wave(10, 10);
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL mid_first_rise: got %0d valids expected 0", q.size()); end
    wave(10, 10);
    tests++; if (q.size() !== 1) begin fails++; $display("FAIL mid_count: got %0d valids expected 1", q.size()); end
    if (q.size() > 0) begin
      tests++;
      if (q[0].per !== 20 || q[0].hi !== 10) begin
        fails++; $display("FAIL mid_value: got %0d/%0d expected 20/10", q[0].per, q[0].hi);
      end
    end
    q.delete();
  endtask

  task automatic test_reset_timeout;
    drive(1'b0, 60);
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL rt_pre_timeout: got %0b expected 1", timeout); end
    reset = 1'b0;
    #1;
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rt_timeout: got %0b expected 0", timeout); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rt_locked: got %0b expected 0", locked); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL rt_state: got %0d expected %0d", dut.state, IDLE); end
    step(2);
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tolerance();
    test_stall();
    test_recovery();
    test_reset_mid();
    test_reset_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
